// File: rtl/jtag_bridge_arbiter_pkg.sv
// Shared debug-bridge constants: arbiter command opcodes, the reserved opcode
// range and the arbiter status-word layout.
package jtag_bridge_arbiter_pkg;

  localparam logic [7:0] CMD_SELECT  = 8'hFC;
  localparam logic [7:0] CMD_ARBSTAT = 8'hFB;

  // Client command sets must stay clear of F8..FD; FE/FF remain client REPORT/RESET.
  localparam logic [7:0] CMD_RSV_LO  = 8'hF8;
  localparam logic [7:0] CMD_RSV_HI  = 8'hFD;

  localparam int ST_TAG_LSB     = 24;
  localparam int ST_CLIENTS_LSB = 16;
  localparam int ST_SEL_LSB     = 8;
  localparam int ST_ERR_BIT     = 0;

  typedef enum logic {
    ST_FWD   = 1'b0,
    ST_REPLY = 1'b1
  } arb_state_t;

  function automatic logic [31:0] status_word(input logic [7:0] clients,
                                              input logic [7:0] sel,
                                              input logic       err);
    logic [31:0] w;
    w = '0;
    w[ST_TAG_LSB +: 8]     = CMD_ARBSTAT;
    w[ST_CLIENTS_LSB +: 8] = clients;
    w[ST_SEL_LSB +: 8]     = sel;
    w[ST_ERR_BIT]          = err;
    return w;
  endfunction

endpackage

// File: rtl/jtag_bridge_arbiter.sv
// Shares one debug bridge req/wr/ack/d/q port between CLIENTS debug clients.
// Host words FC (select) and FB (status) are swallowed; everything else is forwarded.
module jtag_bridge_arbiter
  import jtag_bridge_arbiter_pkg::*;
#(
  parameter  int CLIENTS = 2,
  localparam int SELBITS = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  br_req,
  output logic                  br_wr,
  output logic [31:0]           br_d,
  input  logic [31:0]           br_q,
  input  logic                  br_ack,
  input  logic [CLIENTS-1:0]    cl_req,
  input  logic [CLIENTS-1:0]    cl_wr,
  input  logic [32*CLIENTS-1:0] cl_d,
  output logic [31:0]           cl_q,
  output logic [CLIENTS-1:0]    cl_ack
);

  // Handshake: a word moves only in the cycle br_ack=1; in that same cycle the
  // selected client sees cl_ack=1 (combinational), and br_q is valid for host->core words.

  arb_state_t         state, state_nx;
  logic [SELBITS-1:0] sel;
  logic               err;
  logic [31:0]        status;

  logic               fwd_req, fwd_wr;
  logic [31:0]        fwd_d;
  logic               host_ack, is_select, is_arbstat, swallow, sel_ok;

  always_comb begin
    fwd_req = 1'b0;
    fwd_wr  = 1'b0;
    fwd_d   = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (sel == SELBITS'(i)) begin
        fwd_req = cl_req[i];
        fwd_wr  = cl_wr[i];
        fwd_d   = cl_d[32*i +: 32];
      end
    end
  end

  // Only host->core words seen in FWD are decoded; acks during reset are dropped.
  assign host_ack   = br_ack && !reset;
  assign is_select  = host_ack && (state == ST_FWD) && !fwd_wr && (br_q[31:24] == CMD_SELECT);
  assign is_arbstat = host_ack && (state == ST_FWD) && !fwd_wr && (br_q[31:24] == CMD_ARBSTAT);
  assign swallow    = is_select || is_arbstat;
  assign sel_ok     = ({1'b0, br_q[7:0]} < 9'(CLIENTS));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FWD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FWD:   if (is_arbstat) state_nx = ST_REPLY;
      ST_REPLY: if (host_ack)   state_nx = ST_FWD;
      default:  state_nx = ST_FWD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel    <= '0;
      err    <= 1'b0;
      status <= '0;
    end else begin
      if (is_select) begin
        if (sel_ok) begin
          sel <= br_q[SELBITS-1:0];
          err <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (is_arbstat) status <= status_word(8'(CLIENTS), 8'(sel), err);
    end
  end

  always_comb begin
    br_req = 1'b0;
    br_wr  = 1'b0;
    br_d   = '0;
    cl_ack = '0;
    case (state)
      ST_FWD: begin
        br_req = fwd_req;
        br_wr  = fwd_wr;
        br_d   = fwd_d;
        for (int i = 0; i < CLIENTS; i++)
          cl_ack[i] = host_ack && !swallow && (sel == SELBITS'(i));
      end
      ST_REPLY: begin
        br_req = 1'b1;
        br_wr  = 1'b1;
        br_d   = status;
      end
      default: ;
    endcase
  end

  assign cl_q = br_q;

endmodule

// File: tb/tb_jtag_bridge_arbiter.sv
// Bench for jtag_bridge_arbiter (CLIENTS=2): directed scenarios plus random
// traffic, checked every cycle against a transaction-level model of the arbiter.
module tb_jtag_bridge_arbiter;

  localparam int CLIENTS = 2;
  localparam int OBS_W   = CLIENTS + 2 + 32 + 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  br_req, br_wr, br_ack;
  logic [31:0]           br_d, br_q, cl_q;
  logic [CLIENTS-1:0]    cl_req, cl_wr, cl_ack;
  logic [32*CLIENTS-1:0] cl_d;

  jtag_bridge_arbiter #(.CLIENTS(CLIENTS)) dut (
    .clk(clk), .reset(reset),
    .br_req(br_req), .br_wr(br_wr), .br_d(br_d), .br_q(br_q), .br_ack(br_ack),
    .cl_req(cl_req), .cl_wr(cl_wr), .cl_d(cl_d), .cl_q(cl_q), .cl_ack(cl_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  string            tag_q[$];
  int               vectors = 0;
  int               miscompares = 0;

  // reference model: which client owns the bridge, sticky error, pending reply
  int          m_sel;
  bit          m_err;
  bit          m_reply;
  logic [31:0] m_status;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OBS_W-1:0] exp_v, got_v;
      string            t;
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      got_v = {cl_ack, br_req, br_wr, br_d, cl_q};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s: got ack=%b req=%b wr=%b d=%h q=%h, expected ack=%b req=%b wr=%b d=%h q=%h",
                 t, got_v[OBS_W-1 -: CLIENTS], got_v[65], got_v[64], got_v[63:32], got_v[31:0],
                 exp_v[OBS_W-1 -: CLIENTS], exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
      end
    end
  end

  // Predict this cycle's outputs from current inputs, then advance the model over the edge.
  task automatic step(input string tag, input bit force_d = 1'b0, input logic [31:0] want_d = '0);
    logic [CLIENTS-1:0] e_ack;
    logic               e_req, e_wr;
    logic [31:0]        e_d;
    bit                 c_sel, c_stat;
    c_sel  = 1'b0;
    c_stat = 1'b0;
    e_ack  = '0;
    if (m_reply) begin
      e_req = 1'b1;
      e_wr  = 1'b1;
      e_d   = m_status;
    end else begin
      e_req  = cl_req[m_sel];
      e_wr   = cl_wr[m_sel];
      e_d    = cl_d[32*m_sel +: 32];
      c_sel  = !reset && br_ack && !e_wr && (br_q[31:24] == 8'hFC);
      c_stat = !reset && br_ack && !e_wr && (br_q[31:24] == 8'hFB);
      if (br_ack && !reset && !c_sel && !c_stat) e_ack = CLIENTS'(1 << m_sel);
    end
    if (force_d) e_d = want_d;
    exp_q.push_back({e_ack, e_req, e_wr, e_d, br_q});
    tag_q.push_back(tag);
    @(posedge clk);
    if (reset) begin
      m_sel = 0; m_err = 1'b0; m_reply = 1'b0;
    end else if (m_reply) begin
      if (br_ack) m_reply = 1'b0;
    end else if (c_sel) begin
      if (int'(br_q[7:0]) < CLIENTS) begin
        m_sel = int'(br_q[7:0]); m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (c_stat) begin
      m_reply  = 1'b1;
      m_status = {8'hFB, 8'(CLIENTS), 8'(m_sel), 7'd0, m_err};
    end
    #1;
  endtask

  task automatic host(input string tag, input logic [31:0] word,
                      input bit force_d = 1'b0, input logic [31:0] want_d = '0);
    br_ack = 1'b1;
    br_q   = word;
    step(tag, force_d, want_d);
    br_ack = 1'b0;
  endtask

  task automatic idle(input string tag, input bit force_d = 1'b0, input logic [31:0] want_d = '0);
    br_ack = 1'b0;
    br_q   = $urandom;
    step(tag, force_d, want_d);
  endtask

  initial begin
    reset = 1'b1; br_ack = 1'b0; br_q = '0;
    cl_req = '0; cl_wr = '0; cl_d = {32'hD1D1_0001, 32'hD0D0_0000};
    m_sel = 0; m_err = 1'b0; m_reply = 1'b0; m_status = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cl_req = 2'b11;
    idle("reset_state");
    host("reset_default", 32'h0100_0000);

    host("select_1", 32'hFC00_0001);
    host("word_to_cl1", 32'h0200_0055);
    idle("br_d_from_cl1");

    host("illegal_select", 32'hFC00_0005);
    host("arbstat_err", 32'hFB00_0000);
    idle("status_err", 1'b1, 32'hFB02_0101);
    cl_req = 2'b10; cl_wr = 2'b10; cl_d[63:32] = 32'hC1C1_5A5A;
    idle("reply_holds_off", 1'b1, 32'hFB02_0101);
    host("reply_ack", $urandom, 1'b1, 32'hFB02_0101);
    idle("client_resumes");
    host("client_word_xfer", $urandom);
    cl_wr = 2'b00;
    host("select_0_clear", 32'hFC00_0000);
    host("arbstat_clean", 32'hFB00_0000);
    idle("status_clean", 1'b1, 32'hFB02_0000);
    host("reply_ack_clean", $urandom, 1'b1, 32'hFB02_0000);

    host("select_1_again", 32'hFC00_0001);
    host("arbstat_pre_reset", 32'hFB00_0000);
    idle("reply_pre_reset");
    reset = 1'b1;
    host("ack_in_reset", 32'hFC00_0001);
    reset = 1'b0;
    idle("after_reset");

    cl_req = 2'b01; cl_wr = 2'b01; cl_d[31:0] = 32'hFC00_0001;
    host("write_not_decoded", 32'hFC00_0001);
    cl_wr = 2'b00;
    idle("sel_still_0");

    for (int n = 0; n < 600; n++) begin
      int r;
      reset  = ($urandom_range(0, 49) == 0);
      br_ack = $urandom_range(0, 1);
      r      = $urandom_range(0, 3);
      if (r == 0)      br_q = {8'hFC, 16'h0, 8'($urandom_range(0, 3))};
      else if (r == 1) br_q = {8'hFB, 24'($urandom)};
      else             br_q = $urandom;
      cl_req = CLIENTS'($urandom);
      cl_wr  = CLIENTS'($urandom) & CLIENTS'($urandom);
      cl_d   = {$urandom, $urandom};
      step("random");
    end
    reset = 1'b0; br_ack = 1'b0;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
